// File: rtl/eth_measurer_rx_multi.sv
// Receive-side ping matcher: parses byte-wide frames, matches dst/src MAC and one of
// NUM_CH identifiers, and queues {channel, ping_id, timestamp} events in a FWFT FIFO.
module eth_measurer_rx_multi #(
    parameter logic [47:0] SRC_MAC     = 48'h00_00_00_00_00_00,
    parameter bit          BCAST_ONLY  = 1'b1,
    parameter logic [47:0] LOCAL_MAC   = 48'h00_00_00_00_00_00,
    parameter int          NUM_CH      = 4,
    parameter int          IDENT_BYTES = 4,
    parameter int          ID_BYTES    = 8,
    parameter int          TS_WIDTH    = 64,
    parameter int          FIFO_DEPTH  = 4,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tvalid,
    input  logic [TS_WIDTH-1:0]           current_time,
    input  logic [NUM_CH*8*IDENT_BYTES-1:0] ident_table,
    input  logic [NUM_CH-1:0]             ch_enable,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [CH_W-1:0]               ev_channel,
    output logic [8*ID_BYTES-1:0]         ev_ping_id,
    output logic [TS_WIDTH-1:0]           ev_timestamp,
    output logic [31:0]                   match_count,
    output logic [31:0]                   drop_count
);

    localparam int HDR = 14 + IDENT_BYTES + ID_BYTES;
    localparam int HBW = (HDR - 2) * 8;
    localparam int IW  = 8 * IDENT_BYTES;
    localparam int PW  = 8 * ID_BYTES;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = CH_W + PW + TS_WIDTH;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Stage p0: byte counter, header shift buffer, first-byte timestamp
    logic [15:0]         cnt_p0;
    logic [HBW-1:0]      hdr_p0;
    logic [TS_WIDTH-1:0] ts_p0;

    logic byte_beat;
    logic shift_en;
    assign byte_beat = s_axis_tvalid & s_axis_tkeep;
    // Ethertype bytes are never compared, so they are not stored in the buffer
    assign shift_en  = byte_beat && (cnt_p0 < 16'(HDR)) &&
                       (cnt_p0 != 16'd12) && (cnt_p0 != 16'd13);

    logic [HBW-1:0] hdr_now;
    logic [16:0]    frame_len;
    logic [47:0]    dst_now, src_now;
    logic [IW-1:0]  ident_now;
    logic [PW-1:0]  ping_now;
    assign hdr_now   = shift_en ? {hdr_p0[HBW-9:0], s_axis_tdata} : hdr_p0;
    assign frame_len = {1'b0, cnt_p0} + {16'd0, s_axis_tkeep};
    assign dst_now   = hdr_now[HBW-1 -: 48];
    assign src_now   = hdr_now[HBW-49 -: 48];
    assign ident_now = hdr_now[IW+PW-1 -: IW];
    assign ping_now  = hdr_now[PW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
            hdr_p0 <= '0;
        end else if (s_axis_tvalid) begin
            if (s_axis_tlast)
                cnt_p0 <= '0;
            else if (byte_beat)
                cnt_p0 <= sat_inc16(cnt_p0);
            if (shift_en)
                hdr_p0 <= hdr_now;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_beat && cnt_p0 == 16'd0)
            ts_p0 <= current_time;
    end

    logic            id_hit;
    logic [CH_W-1:0] hit_ch;
    // Scan downwards so the lowest matching channel is the one left standing
    always_comb begin
        id_hit = 1'b0;
        hit_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_enable[k] && ident_table[k*IW +: IW] == ident_now) begin
                id_hit = 1'b1;
                hit_ch = CH_W'(k);
            end
        end
    end

    logic dst_ok, src_ok, match;
    assign dst_ok = (dst_now == BCAST) || (!BCAST_ONLY && dst_now == LOCAL_MAC);
    assign src_ok = (src_now == SRC_MAC);
    assign match  = s_axis_tvalid & s_axis_tlast & ~s_axis_tuser &
                    (frame_len >= 17'(HDR)) & dst_ok & src_ok & id_hit;

    // Stage p1: event FIFO and counters
    logic [EW-1:0] mem_p1 [FIFO_DEPTH];
    logic [AW-1:0] rd_p1, wr_p1;
    logic [AW:0]   occ_p1;
    logic [EW-1:0] hold_p1;
    logic [31:0]   match_cnt_p1, drop_cnt_p1;

    logic full, pop, push, drop;
    assign full = (occ_p1 == (AW+1)'(FIFO_DEPTH));
    assign pop  = ev_valid & ev_ready;
    assign push = match & (~full | pop);
    assign drop = match & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_p1        <= '0;
            wr_p1        <= '0;
            occ_p1       <= '0;
            hold_p1      <= '0;
            match_cnt_p1 <= '0;
            drop_cnt_p1  <= '0;
        end else begin
            if (push) begin
                wr_p1        <= wr_p1 + 1'b1;
                match_cnt_p1 <= sat_inc32(match_cnt_p1);
            end
            if (pop) begin
                rd_p1   <= rd_p1 + 1'b1;
                hold_p1 <= mem_p1[rd_p1];
            end
            if (drop)
                drop_cnt_p1 <= sat_inc32(drop_cnt_p1);
            occ_p1 <= occ_p1 + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_p1[wr_p1] <= {hit_ch, ping_now, ts_p0};
    end

    // The last popped entry stays on the outputs while the FIFO is empty
    logic [EW-1:0] head;
    assign head         = (occ_p1 != '0) ? mem_p1[rd_p1] : hold_p1;
    assign ev_valid     = (occ_p1 != '0);
    assign ev_channel   = head[EW-1 -: CH_W];
    assign ev_ping_id   = head[PW+TS_WIDTH-1 -: PW];
    assign ev_timestamp = head[TS_WIDTH-1:0];
    assign match_count  = match_cnt_p1;
    assign drop_count   = drop_cnt_p1;

endmodule

// File: doc/eth_measurer_rx_multi.md
Name: eth_measurer_rx_multi

Overview:
Single-clock receive-side ping matcher for the measurer cores, the parametrised successor of the single-identifier receiver. It parses byte-wide AXI-Stream frames from the TEMAC and matches destination MAC, source MAC and one of NUM_CH runtime-configurable identifiers. For each matching frame it queues an event {channel, ping_id, timestamp} into a small FIFO with a valid/ready output, and keeps saturating match and drop counters.

Parameters:
SRC_MAC, 48'h00_00_00_00_00_00, peer MAC that must appear in bytes 6-11.
BCAST_ONLY, 1, 1: destination must be FF:FF:FF:FF:FF:FF; 0: destination must equal LOCAL_MAC or broadcast.
LOCAL_MAC, 48'h00_00_00_00_00_00, own MAC, used when BCAST_ONLY=0.
NUM_CH, 4, number of identifier channels (1..8).
IDENT_BYTES, 4, identifier length in bytes (1..8).
ID_BYTES, 8, ping id length in bytes (1..8).
TS_WIDTH, 64, timestamp width.
FIFO_DEPTH, 4, event FIFO depth (power of 2, ≥2).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_axis_tdata  in  8  frame byte
s_axis_tkeep  in  1  byte qualifier
s_axis_tlast  in  1  last beat of frame
s_axis_tuser  in  1  frame error flag, valid on the tlast beat
s_axis_tvalid  in  1  beat valid (no ready; always accepted)
current_time  in  TS_WIDTH  free-running time
ident_table  in  NUM_CH*8*IDENT_BYTES  channel k identifier at slice k
ch_enable  in  NUM_CH  per-channel enable
ev_valid  out  1  event available
ev_ready  in  1  event consumed
ev_channel  out  max(1,clog2(NUM_CH))  matched channel
ev_ping_id  out  8*ID_BYTES  ping id
ev_timestamp  out  TS_WIDTH  time of first frame byte
match_count  out  32  accepted events, saturating
drop_count  out  32  matches lost to full FIFO, saturating

Behaviour:
- HDR = 14 + IDENT_BYTES + ID_BYTES. Layout: dst[0:5], src[6:11], ethertype[12:13] (ignored), identifier, ping_id, big-endian.
- Reset (rst_n=0 at posedge): byte count=0, header buffer=0, FIFO empty, ev_valid=0, ev_* outputs 0, counters 0. A frame in progress at reset release is parsed as if it started at the first beat after reset.
- Byte beat = tvalid & tkeep. A byte beat with count < HDR shifts the byte into the header buffer. Count increments per byte beat and saturates at 16'hFFFF.
- A beat with tvalid & ~tkeep advances nothing. If it carries tlast, it still ends the frame.
- First byte beat of a frame (count==0) latches current_time.
- On a tvalid & tlast beat: evaluate the match using header bytes including the current beat. Then count returns to 0 on the next edge.
- Frame length L = count + (tkeep ? 1 : 0). Match requires all of:
  - L ≥ HDR;
  - tuser=0;
  - destination and source checks pass;
  - some enabled channel identifier is equal. If several match, the lowest index wins.
- On a match, push the event at that edge, and match_count++ (saturating). If the FIFO is full and no pop occurs in the same cycle: drop the event, drop_count++ (saturating), match_count unchanged. If full and popping in the same cycle: the push succeeds.
- FIFO is first-word-fall-through. ev_valid rises the cycle after the push edge (latency 1) and ev_* show the head entry. A pop occurs when ev_valid & ev_ready.
- ev_* hold stable while ev_valid=1 and ev_ready=0. ev_* hold their last value when empty.
- Back-to-back frames (tlast followed by a byte on the next cycle) are fully supported.
- ident_table and ch_enable are sampled only on the tlast beat.

Test Plan:
1. Defaults, SRC_MAC=48'h02_00_00_00_00_01. Send a 60-byte frame: dst FF..FF, src 02:00:00:00:00:01, ident 0xDEADBEEF in ch2, ping_id 0x0102030405060708, current_time=1000 at first byte. -> One cycle after tlast: ev_valid=1, ev_channel=2, ev_ping_id=0x0102030405060708, ev_timestamp=1000, match_count=1.
2. Same frame with tuser=1, then with wrong src, then with ch2 disabled, then truncated to L=25. -> No event; both counters stay 0. L=26 with otherwise correct content -> event.
3. ev_ready=0, six matching back-to-back frames. -> 4 events queued in order, drop_count=2. Then ev_ready=1 drains ping ids in arrival order.
4. FIFO full with ev_ready=1 in the tlast cycle of a matching frame. -> Push accepted, drop_count unchanged, occupancy stays 4.
5. Same ident loaded in ch1 and ch3, both enabled. -> ev_channel=1. With BCAST_ONLY=0, dst=LOCAL_MAC -> match; dst=other unicast -> no match.
6. Assert rst_n=0 mid-frame with 2 events queued. -> ev_valid=0 and counters 0 after the edge. The remainder of that frame, parsed from the first post-reset beat, produces no event.
